// File: rtl/rect_fill_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rect_fill_pkg
// Brief    : Shared states, register map and bit positions for rect_fill_engine.
// Revision : 1.0 - initial release
// ============================================================================
package rect_fill_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_FILL  = 2'd2,
        ST_DONE  = 2'd3
    } fillState_t;

    localparam int COORD_W = 9;

    localparam logic [7:0] ADDR_X0_L   = 8'h00;
    localparam logic [7:0] ADDR_X0_H   = 8'h01;
    localparam logic [7:0] ADDR_Y0_L   = 8'h02;
    localparam logic [7:0] ADDR_Y0_H   = 8'h03;
    localparam logic [7:0] ADDR_X1_L   = 8'h04;
    localparam logic [7:0] ADDR_X1_H   = 8'h05;
    localparam logic [7:0] ADDR_Y1_L   = 8'h06;
    localparam logic [7:0] ADDR_Y1_H   = 8'h07;
    localparam logic [7:0] ADDR_COLOR  = 8'h08;
    localparam logic [7:0] ADDR_CTRL   = 8'h09;
    localparam logic [7:0] ADDR_STATUS = 8'h0A;

    localparam int CTRL_START_BIT   = 0;
    localparam int CTRL_OUTLINE_BIT = 1;
    localparam int STATUS_BUSY_BIT  = 0;
    localparam int STATUS_ERR_BIT   = 1;

    localparam int DEFAULT_COLS = 240;
    localparam int DEFAULT_ROWS = 320;

endpackage
`default_nettype wire

// File: rtl/rect_fill_regs.sv
`default_nettype none
// ============================================================================
// Module   : rect_fill_regs
// Brief    : Wishbone decode, register file, ACK/RTY and busy-write lockout.
// Options  : RECT_FILL_OUTLINE_EN (CTRL bit1 storage)
// Revision : 1.0 - initial release
// ============================================================================
module rect_fill_regs
    import rect_fill_pkg::*;
(
    input  logic               CLK_I,
    input  logic               RST_I,
    input  logic               WE_I,
    input  logic               STB_I,
    input  logic [7:0]         ADR_I,
    input  logic [7:0]         DAT_I,
    output logic               ACK_O,
    output logic               RTY_O,
    output logic [7:0]         DAT_O,
    input  logic               engineBusy,
    input  logic               engineErr,
    output logic [COORD_W-1:0] x0,
    output logic [COORD_W-1:0] y0,
    output logic [COORD_W-1:0] x1,
    output logic [COORD_W-1:0] y1,
    output logic [7:0]         color,
    output logic               startReq,
    output logic               startOutline
);

    logic               r_stbPrev;
    logic               r_ack;
    logic               r_rty;
    logic [7:0]         r_dat;
    logic               r_start;
    logic [COORD_W-1:0] r_x0, r_y0, r_x1, r_y1;
    logic [7:0]         r_color;
    logic [7:0]         w_rdData;
    logic [7:0]         w_ctrlRd;
    logic               w_newReq;
    logic               w_busy;
    logic               w_refuse;
    logic               w_write;

    // A pending START counts as busy so a back-to-back write cannot slip in.
    assign w_newReq = STB_I & ~r_stbPrev;
    assign w_busy   = engineBusy | r_start;
    assign w_refuse = w_newReq & WE_I & w_busy & (ADR_I <= ADDR_CTRL);
    assign w_write  = w_newReq & WE_I & ~w_refuse;

`ifdef RECT_FILL_OUTLINE_EN
    logic r_outline;
    always_comb begin
        w_ctrlRd                   = 8'h00;
        w_ctrlRd[CTRL_OUTLINE_BIT] = r_outline;
    end
    assign startOutline = r_outline;
`else
    assign w_ctrlRd     = 8'h00;
    assign startOutline = 1'b0;
`endif

    always_comb begin
        w_rdData = 8'h00;
        case (ADR_I)
            ADDR_X0_L:   w_rdData = r_x0[7:0];
            ADDR_X0_H:   w_rdData = {7'b0, r_x0[8]};
            ADDR_Y0_L:   w_rdData = r_y0[7:0];
            ADDR_Y0_H:   w_rdData = {7'b0, r_y0[8]};
            ADDR_X1_L:   w_rdData = r_x1[7:0];
            ADDR_X1_H:   w_rdData = {7'b0, r_x1[8]};
            ADDR_Y1_L:   w_rdData = r_y1[7:0];
            ADDR_Y1_H:   w_rdData = {7'b0, r_y1[8]};
            ADDR_COLOR:  w_rdData = r_color;
            ADDR_CTRL:   w_rdData = w_ctrlRd;
            ADDR_STATUS: begin
                w_rdData[STATUS_BUSY_BIT] = w_busy;
                w_rdData[STATUS_ERR_BIT]  = engineErr;
            end
            default:     w_rdData = 8'h00;
        endcase
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            r_stbPrev <= 1'b0;
            r_ack     <= 1'b0;
            r_rty     <= 1'b0;
            r_dat     <= 8'h00;
            r_start   <= 1'b0;
            r_x0      <= '0;
            r_y0      <= '0;
            r_x1      <= '0;
            r_y1      <= '0;
            r_color   <= 8'h00;
`ifdef RECT_FILL_OUTLINE_EN
            r_outline <= 1'b0;
`endif
        end else begin
            r_stbPrev <= STB_I;
            r_ack     <= w_newReq & ~w_refuse;
            r_rty     <= w_refuse;
            r_dat     <= (w_newReq & ~WE_I) ? w_rdData : 8'h00;
            r_start   <= w_write & (ADR_I == ADDR_CTRL) & DAT_I[CTRL_START_BIT];
            if (w_write) begin
                case (ADR_I)
                    ADDR_X0_L:  r_x0[7:0] <= DAT_I;
                    ADDR_X0_H:  r_x0[8]   <= DAT_I[0];
                    ADDR_Y0_L:  r_y0[7:0] <= DAT_I;
                    ADDR_Y0_H:  r_y0[8]   <= DAT_I[0];
                    ADDR_X1_L:  r_x1[7:0] <= DAT_I;
                    ADDR_X1_H:  r_x1[8]   <= DAT_I[0];
                    ADDR_Y1_L:  r_y1[7:0] <= DAT_I;
                    ADDR_Y1_H:  r_y1[8]   <= DAT_I[0];
                    ADDR_COLOR: r_color   <= DAT_I;
`ifdef RECT_FILL_OUTLINE_EN
                    ADDR_CTRL:  r_outline <= DAT_I[CTRL_OUTLINE_BIT];
`endif
                    default: ;
                endcase
            end
        end
    end

    assign ACK_O    = r_ack;
    assign RTY_O    = r_rty;
    assign DAT_O    = r_dat;
    assign x0       = r_x0;
    assign y0       = r_y0;
    assign x1       = r_x1;
    assign y1       = r_y1;
    assign color    = r_color;
    assign startReq = r_start;

endmodule
`default_nettype wire

// File: rtl/rect_fill_engine.sv
`default_nettype none
// ============================================================================
// Module   : rect_fill_engine
// Brief    : Wishbone-driven rectangle fill into an 8bpp framebuffer.
// Options  : RECT_FILL_OUTLINE_EN (outline-only interior rows)
// Revision : 1.0 - initial release
// ============================================================================
module rect_fill_engine
    import rect_fill_pkg::*;
#(
    parameter int COLS      = DEFAULT_COLS,
    parameter int ROWS      = DEFAULT_ROWS,
    parameter int FB_ADDR_W = 17
)
(
    input  logic                 CLK_I,
    input  logic                 RST_I,
    input  logic                 WE_I,
    input  logic                 STB_I,
    input  logic [7:0]           ADR_I,
    input  logic [7:0]           DAT_I,
    output logic                 ACK_O,
    output logic                 RTY_O,
    output logic [7:0]           DAT_O,
    output logic [FB_ADDR_W-1:0] fbAddr,
    output logic [7:0]           fbData,
    output logic                 fbWe,
    input  logic                 fbReady,
    output logic                 fillDone
);

    localparam logic [1:0] c_ST_IDLE  = ST_IDLE;
    localparam logic [1:0] c_ST_CHECK = ST_CHECK;
    localparam logic [1:0] c_ST_FILL  = ST_FILL;
    localparam logic [1:0] c_ST_DONE  = ST_DONE;

    localparam logic [COORD_W-1:0]   c_XMAX = COORD_W'(COLS - 1);
    localparam logic [COORD_W-1:0]   c_YMAX = COORD_W'(ROWS - 1);
    localparam logic [FB_ADDR_W-1:0] c_COLS = FB_ADDR_W'(COLS);

    logic [COORD_W-1:0]   w_x0, w_y0, w_x1, w_y1;
    logic [7:0]           w_color;
    logic                 w_startReq;
    logic                 w_startOutline;

    logic [1:0]           r_state;
    logic [COORD_W-1:0]   r_x, r_y;
    logic [FB_ADDR_W-1:0] r_rowBase;
    logic [FB_ADDR_W-1:0] r_fbAddr;
    logic [7:0]           r_fbData;
    logic                 r_fbWe;
    logic                 r_fillDone;
    logic                 r_err;
    logic [7:0]           r_color;
    logic                 r_outline;

    logic                 w_rowEnd;
    logic                 w_lastPix;
    logic                 w_interior;
    logic                 w_reject;
    logic [COORD_W-1:0]   w_xNext;
    logic [FB_ADDR_W-1:0] w_rowNext;
    logic [FB_ADDR_W-1:0] w_startBase;

    rect_fill_regs u_regs (
        .CLK_I        (CLK_I),
        .RST_I        (RST_I),
        .WE_I         (WE_I),
        .STB_I        (STB_I),
        .ADR_I        (ADR_I),
        .DAT_I        (DAT_I),
        .ACK_O        (ACK_O),
        .RTY_O        (RTY_O),
        .DAT_O        (DAT_O),
        .engineBusy   (r_state != c_ST_IDLE),
        .engineErr    (r_err),
        .x0           (w_x0),
        .y0           (w_y0),
        .x1           (w_x1),
        .y1           (w_y1),
        .color        (w_color),
        .startReq     (w_startReq),
        .startOutline (w_startOutline)
    );

    // Coordinates stay stable during a fill because the register file refuses writes while busy.
    assign w_reject    = (w_x0 > w_x1) | (w_y0 > w_y1) | (w_x1 > c_XMAX) | (w_y1 > c_YMAX);
    assign w_startBase = FB_ADDR_W'(w_y0) * c_COLS;

    assign w_rowEnd   = (r_x == w_x1);
    assign w_lastPix  = w_rowEnd & (r_y == w_y1);
    assign w_interior = r_outline & (r_y != w_y0) & (r_y != w_y1);
    assign w_xNext    = w_rowEnd                     ? w_x0 :
                        (w_interior & (r_x == w_x0)) ? w_x1 :
                                                       r_x + 1'b1;
    assign w_rowNext  = w_rowEnd ? r_rowBase + c_COLS : r_rowBase;

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            r_state    <= c_ST_IDLE;
            r_x        <= '0;
            r_y        <= '0;
            r_rowBase  <= '0;
            r_fbAddr   <= '0;
            r_fbData   <= 8'h00;
            r_fbWe     <= 1'b0;
            r_fillDone <= 1'b0;
            r_err      <= 1'b0;
            r_color    <= 8'h00;
            r_outline  <= 1'b0;
        end else begin
            r_fillDone <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_startReq) begin
                        r_err     <= 1'b0;
                        r_color   <= w_color;
                        r_outline <= w_startOutline;
                        r_state   <= c_ST_CHECK;
                    end
                end
                c_ST_CHECK: begin
                    if (w_reject) begin
                        r_err      <= 1'b1;
                        r_fillDone <= 1'b1;
                        r_state    <= c_ST_IDLE;
                    end else begin
                        r_x       <= w_x0;
                        r_y       <= w_y0;
                        r_rowBase <= w_startBase;
                        r_fbAddr  <= w_startBase + FB_ADDR_W'(w_x0);
                        r_fbData  <= r_color;
                        r_fbWe    <= 1'b1;
                        r_state   <= c_ST_FILL;
                    end
                end
                c_ST_FILL: begin
                    if (fbReady) begin
                        if (w_lastPix) begin
                            r_fbWe     <= 1'b0;
                            r_fillDone <= 1'b1;
                            r_state    <= c_ST_DONE;
                        end else begin
                            r_x       <= w_xNext;
                            r_rowBase <= w_rowNext;
                            r_fbAddr  <= w_rowNext + FB_ADDR_W'(w_xNext);
                            if (w_rowEnd) begin
                                r_y <= r_y + 1'b1;
                            end
                        end
                    end
                end
                c_ST_DONE: begin
                    r_state <= c_ST_IDLE;
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign fbAddr   = r_fbAddr;
    assign fbData   = r_fbData;
    assign fbWe     = r_fbWe;
    assign fillDone = r_fillDone;

endmodule
`default_nettype wire

// File: tb/tb_rect_fill_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_rect_fill_engine
// Brief    : Self-checking bench for rect_fill_engine against a pixel-list model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_rect_fill_engine;
    import rect_fill_pkg::*;

    localparam int COLS = 240;
    localparam int ROWS = 320;
    localparam int AW   = 17;
`ifdef RECT_FILL_OUTLINE_EN
    localparam bit OL_EN = 1'b1;
`else
    localparam bit OL_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          we = 1'b0, stb = 1'b0;
    logic [7:0]    adr = 8'h00, dat = 8'h00;
    logic          ack, rty, fbWe, fillDone;
    logic [7:0]    rdat, fbData;
    logic [AW-1:0] fbAddr;
    logic          fbReady = 1'b1;

    rect_fill_engine #(.COLS(COLS), .ROWS(ROWS), .FB_ADDR_W(AW)) dut (
        .CLK_I(clk), .RST_I(rst), .WE_I(we), .STB_I(stb), .ADR_I(adr), .DAT_I(dat),
        .ACK_O(ack), .RTY_O(rty), .DAT_O(rdat),
        .fbAddr(fbAddr), .fbData(fbData), .fbWe(fbWe), .fbReady(fbReady),
        .fillDone(fillDone)
    );

    always #5 clk = ~clk;

    int nChecks = 0, nErrors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // 0: always ready, 1: random, 2: repeating 1-0-0-1
    int readyMode = 0;
    always @(posedge clk) begin
        #1;
        case (readyMode)
            0:       fbReady = 1'b1;
            1:       fbReady = 1'($urandom % 2);
            default: fbReady = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: every pixel of the rectangle in raster order, y*COLS+x.
    int expQ[$];
    task automatic buildExpected(input int x0, input int y0, input int x1, input int y1, input bit ol);
        for (int y = y0; y <= y1; y++)
            for (int x = x0; x <= x1; x++)
                if (!(ol && y != y0 && y != y1 && x != x0 && x != x1))
                    expQ.push_back(y * COLS + x);
    endtask

    logic [7:0]    expColor;
    int            accepted, firstAddr, lastAddr, firstWeCyc, doneCyc, doneCount = 0;
    bit            seenWe;
    logic          prevStall = 1'b0;
    logic [AW-1:0] prevAddr;
    logic [7:0]    prevData;

    always @(negedge clk) begin
        int e;
        if (rst) begin
            prevStall = 1'b0;
        end else begin
            if (fbWe) begin
                if (prevStall) begin
                    check("stall_addr", 32'(fbAddr), 32'(prevAddr));
                    check("stall_data", 32'(fbData), 32'(prevData));
                end
                if (!seenWe) begin
                    seenWe = 1'b1;
                    firstWeCyc = cyc;
                end
                if (fbReady) begin
                    if (expQ.size() == 0) begin
                        nChecks++;
                        nErrors++;
                        $display("FAIL unexpected_write: addr %0d accepted, none expected", fbAddr);
                    end else begin
                        e = expQ.pop_front();
                        check("pix_addr", 32'(fbAddr), 32'(e));
                        check("pix_data", 32'(fbData), 32'(expColor));
                    end
                    if (accepted == 0) firstAddr = int'(fbAddr);
                    lastAddr = int'(fbAddr);
                    accepted++;
                end
            end
            prevStall = fbWe && !fbReady;
            prevAddr  = fbAddr;
            prevData  = fbData;
            if (fillDone) begin
                doneCount++;
                doneCyc = cyc;
            end
        end
    end

    task automatic wb(input logic w, input logic [7:0] a, input logic [7:0] d,
                      output logic gAck, output logic gRty, output logic [7:0] gDat);
        @(posedge clk); #1;
        stb = 1'b1; we = w; adr = a; dat = d;
        @(posedge clk); #1;
        stb = 1'b0; we = 1'b0;
        @(negedge clk);
        gAck = ack; gRty = rty; gDat = rdat;
    endtask

    task automatic wrReg(input logic [7:0] a, input logic [7:0] d);
        logic k, r; logic [7:0] x;
        wb(1'b1, a, d, k, r, x);
        check("wr_ack", 32'(k), 1);
        check("wr_rty", 32'(r), 0);
    endtask

    task automatic rdCheck(input string name, input logic [7:0] a, input logic [7:0] exp);
        logic k, r; logic [7:0] x;
        wb(1'b0, a, 8'h00, k, r, x);
        check("rd_ack", 32'(k), 1);
        check(name, 32'(x), 32'(exp));
    endtask

    int ackCyc, startDone, fillPixels;
    bit fillValid;

    task automatic startFill(input int x0, input int y0, input int x1, input int y1,
                             input logic [7:0] col, input bit ol);
        wrReg(ADDR_X0_L, 8'(x0)); wrReg(ADDR_X0_H, 8'(x0 >> 8));
        wrReg(ADDR_Y0_L, 8'(y0)); wrReg(ADDR_Y0_H, 8'(y0 >> 8));
        wrReg(ADDR_X1_L, 8'(x1)); wrReg(ADDR_X1_H, 8'(x1 >> 8));
        wrReg(ADDR_Y1_L, 8'(y1)); wrReg(ADDR_Y1_H, 8'(y1 >> 8));
        wrReg(ADDR_COLOR, col);
        expQ.delete();
        fillValid = !(x0 > x1 || y0 > y1 || x1 >= COLS || y1 >= ROWS);
        if (fillValid) buildExpected(x0, y0, x1, y1, ol && OL_EN);
        fillPixels = expQ.size();
        expColor   = col;
        accepted   = 0;
        seenWe     = 1'b0;
        startDone  = doneCount;
        wrReg(ADDR_CTRL, 8'(1 + 2 * int'(ol)));
        ackCyc = cyc;
    endtask

    task automatic waitFill(input string name);
        int bound, n;
        bound = fillPixels * 4 + 60;
        n = 0;
        while (doneCount == startDone && n < bound) begin
            @(posedge clk);
            n++;
        end
        if (doneCount == startDone) begin
            nChecks++;
            nErrors++;
            $display("FAIL %s_timeout: no fillDone within %0d cycles", name, bound);
        end
        repeat (2) @(posedge clk);
        check({name, "_done_pulses"}, 32'(doneCount - startDone), 1);
        check({name, "_pixels_left"}, 32'(expQ.size()), 0);
        check({name, "_pixels"}, 32'(accepted), 32'(fillPixels));
        if (fillPixels > 0) begin
            check({name, "_latency_ok"}, 32'(seenWe && (firstWeCyc - ackCyc) <= 5), 1);
            if (readyMode == 0)
                check({name, "_throughput"}, 32'(doneCyc - firstWeCyc), 32'(fillPixels));
        end
        rdCheck({name, "_status"}, ADDR_STATUS, fillValid ? 8'h00 : 8'h02);
    endtask

    int pinA[6] = '{722, 723, 724, 962, 963, 964};
    int pinB[8] = '{0, 1, 2, 240, 242, 480, 481, 482};

    initial begin
        logic k, r; logic [7:0] x;
        int x0, y0, x1, y1, t;

        // The model itself, against hand-worked address lists
        buildExpected(2, 3, 4, 4, 1'b0);
        check("pin_solid_size", 32'(expQ.size()), 6);
        for (int i = 0; i < 6 && i < expQ.size(); i++) check("pin_solid_addr", 32'(expQ[i]), 32'(pinA[i]));
        expQ.delete();
        buildExpected(0, 0, 2, 2, 1'b1);
        check("pin_outline_size", 32'(expQ.size()), 8);
        for (int i = 0; i < 8 && i < expQ.size(); i++) check("pin_outline_addr", 32'(expQ[i]), 32'(pinB[i]));
        expQ.delete();

        @(negedge clk);
        check("rst_ack", 32'(ack), 0);
        check("rst_rty", 32'(rty), 0);
        check("rst_dat", 32'(rdat), 0);
        check("rst_fbWe", 32'(fbWe), 0);
        check("rst_fbAddr", 32'(fbAddr), 0);
        check("rst_fbData", 32'(fbData), 0);
        check("rst_fillDone", 32'(fillDone), 0);
        @(posedge clk); #1 rst = 1'b0;
        rdCheck("rst_status", ADDR_STATUS, 8'h00);
        rdCheck("rst_x1l", ADDR_X1_L, 8'h00);
        rdCheck("unmapped_rd", 8'h3C, 8'h00);
        wrReg(8'h3C, 8'hFF);

        readyMode = 0;
        startFill(2, 3, 4, 4, 8'hE0, 1'b0);
        waitFill("basic");
        rdCheck("ctrl_rd", ADDR_CTRL, OL_EN ? 8'h00 : 8'h00);

        startFill(5, 7, 5, 7, 8'h3A, 1'b0);
        waitFill("one_px");
        check("one_px_addr", 32'(lastAddr), 7 * 240 + 5);

        startFill(0, 0, 240, 3, 8'h11, 1'b0);
        waitFill("x_oob");
        startFill(9, 0, 3, 3, 8'h11, 1'b0);
        waitFill("x_swap");
        startFill(0, 5, 3, 320, 8'h11, 1'b0);
        waitFill("y_oob");

        readyMode = 2;
        startFill(100, 200, 104, 202, 8'h5A, 1'b0);
        waitFill("toggle");

        readyMode = 1;
        startFill(10, 10, 29, 29, 8'h1C, 1'b0);
        wb(1'b1, ADDR_COLOR, 8'h55, k, r, x);
        check("busy_wr_rty", 32'(r), 1);
        check("busy_wr_ack", 32'(k), 0);
        wb(1'b0, ADDR_STATUS, 8'h00, k, r, x);
        check("busy_rd_ack", 32'(k), 1);
        check("busy_rd_bit", 32'(x[0]), 1);
        waitFill("busy");
        rdCheck("color_kept", ADDR_COLOR, 8'h1C);

        readyMode = 0;
        startFill(0, 0, 2, 2, 8'hC3, 1'b1);
        waitFill("outline");

        startFill(0, 0, COLS - 1, ROWS - 1, 8'h77, 1'b0);
        waitFill("full");
        check("full_count", 32'(accepted), 76800);
        check("full_first", 32'(firstAddr), 0);
        check("full_last", 32'(lastAddr), 76799);

        startFill(0, 0, 49, 9, 8'h99, 1'b0);
        repeat (20) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_fbWe", 32'(fbWe), 0);
        check("rst_mid_done", 32'(fillDone), 0);
        expQ.delete();
        @(posedge clk); #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        check("rst_mid_no_done", 32'(doneCount - startDone), 0);
        rdCheck("rst_mid_status", ADDR_STATUS, 8'h00);
        rdCheck("rst_mid_color", ADDR_COLOR, 8'h00);

        for (int i = 0; i < 14; i++) begin
            x0 = $urandom_range(0, COLS - 1);
            y0 = $urandom_range(0, ROWS - 1);
            x1 = x0 + $urandom_range(0, 7);
            y1 = y0 + $urandom_range(0, 5);
            if ($urandom_range(0, 5) == 0) begin
                t = x0; x0 = x1; x1 = t;
            end
            readyMode = $urandom_range(0, 2);
            startFill(x0, y0, x1, y1, 8'($urandom), 1'($urandom));
            waitFill("rand");
        end

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
`default_nettype wire
